obj_list_ctrl: RTL and testbench
================================

Name: obj_list_ctrl

Overview:
- Owns the object list consumed by basic_graph, replacing the ad-hoc add-on-button-edge logic with a proper sequencer.
- Two requesters (key/input logic and animation logic) issue ADD/UPDATE/DELETE/CLEAR ops via req/ack handshake; a round-robin arbiter serialises them onto a shadow list.
- The shadow list is committed to the display list (obj_arr_packed, arr_len) only on a frame_start pulse, so the renderer never sees a half-edited list mid-frame.

Parameters:
- OBJ_WIDTH, 56, object record width: enum[55:52] x[51:42] y[41:32] width[31:22] height[21:12] color[11:0]
- MAX_LEN, 16, list capacity
- N_REQ, 2, number of requesters (fixed to 2 in this revision)

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous reset, active-high
- frame_start  in  1  one-cycle pulse in the clk domain at the start of vertical blank
- req  in  N_REQ  per-requester request level
- req_op  in  2*N_REQ  op per requester: 0 ADD, 1 UPDATE, 2 DELETE, 3 CLEAR
- req_idx  in  4*N_REQ  target slot for UPDATE/DELETE
- req_obj  in  OBJ_WIDTH*N_REQ  object record for ADD/UPDATE
- ack  out  N_REQ  one-cycle completion pulse to the granted requester
- err  out  N_REQ  valid with ack; 1 = op rejected, list unchanged
- obj_arr_packed  out  OBJ_WIDTH*MAX_LEN  committed display list, slot i at [(i+1)*OBJ_WIDTH-1 : i*OBJ_WIDTH]
- arr_len  out  6  committed object count, 0..MAX_LEN
- busy  out  1  high when state != IDLE or a commit is pending

Behaviour:
- Reset (clk edge with rst=1): shadow and display slots all zero, shadow_len = arr_len = 0, ack = err = 0, busy = 0, RR pointer -> requester 0, commit_pending = 0, state IDLE. Reset mid-operation discards the op; no ack is issued.
- Handshake: requester raises req with op/idx/obj stable and holds them until its ack; it drops req in the cycle after ack. At most one ack per cycle.
- Arbitration in IDLE: if commit_pending or frame_start, do COMMIT first (no grant that cycle). Otherwise grant the requester that has req set and is first at or after the RR pointer. After a grant the pointer moves to grantee+1 mod N_REQ.
- FSM states:
  - IDLE.
  - EXEC: latch the op and apply it to the shadow list.
  - MOVE: second DELETE cycle.
  - RESP: drive ack/err for one cycle, then IDLE.
  - COMMIT: one cycle; copy the whole shadow list and shadow_len to the display outputs, clear commit_pending, then IDLE.
- Op semantics (shadow list only):
  - ADD: if shadow_len == MAX_LEN, err=1 and no change (no wrap to 0). Else slot[shadow_len] <= obj; shadow_len += 1.
  - UPDATE: if idx >= shadow_len, err=1. Else slot[idx] <= obj.
  - DELETE: if idx >= shadow_len, err=1. Else in MOVE, slot[idx] <= slot[shadow_len-1]; slot[shadow_len-1] <= 0; shadow_len -= 1. This is swap-with-last, so order is not preserved. idx == shadow_len-1 just zeroes that slot.
  - CLEAR: shadow_len <= 0; all slots zeroed; never errors.
- Latency from the grant cycle to ack: ADD/UPDATE/CLEAR = 2 clk (EXEC, RESP); DELETE = 3 clk (EXEC, MOVE, RESP).
- frame_start while state != IDLE: set commit_pending; COMMIT runs on the next IDLE cycle, ahead of any pending grant. frame_start arriving during COMMIT is absorbed and does not cause a second commit.
- Display outputs change only in COMMIT; they are registered and glitch-free.
- Width rules: shadow_len is 6 bits, compared against MAX_LEN unsigned. idx is zero-extended before comparison.

Decomposition:
- Shared package/header obj_pkg holds:
  - OBJ_WIDTH
  - field bit positions (ENUM/X/Y/WIDTH/HEIGHT/COLOR L/R)
  - op encodings OP_ADD/OP_UPDATE/OP_DELETE/OP_CLEAR
  - colour constants
- basic_graph and painter successors include the same package.
- One sub-module: rr_arbiter (N_REQ requests, enable, grant one-hot, pointer update on enable).

Test Plan:
- Reset, then req0 ADD {0,100,100,100,100,GREEN}, then frame_start -> ack0 2 clk after grant with err0=0; arr_len stays 0 until the COMMIT cycle; after it arr_len=1 and slot0=that record.
- 16 ADDs then a 17th ADD -> 17th acks with err=1; shadow_len stays 16; after commit arr_len=16 (no wrap to 0).
- List A,B,C committed; DELETE idx0 then commit -> arr_len=2, slot0=C, slot1=B, slot2=0; DELETE idx3 -> err=1.
- req0 and req1 asserted together and held over repeated ops -> grants alternate 0,1,0,1; exactly one ack per op; no lost request.
- frame_start pulse during a DELETE EXEC cycle -> commit occurs in the first IDLE cycle after RESP, before the next grant; display shows the post-delete list.
- rst asserted during MOVE -> no ack; all outputs zero next cycle; a subsequent ADD works normally.

Source files
------------

// File: rtl/obj_pkg.sv
// ============================================================================
//  Module   : obj_pkg
//  Purpose  : Object record layout, list op encodings and colour constants
//             shared by the object list controller and the renderers.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package obj_pkg;

  // Object record: enum[55:52] x[51:42] y[41:32] width[31:22] height[21:12] color[11:0]
  localparam int OBJ_WIDTH = 56;
  localparam int IDX_W     = 4;   // slot index width (list capacity up to 16)
  localparam int LEN_W     = 6;   // list length counter width

  localparam int ENUM_L   = 55;
  localparam int ENUM_R   = 52;
  localparam int X_L      = 51;
  localparam int X_R      = 42;
  localparam int Y_L      = 41;
  localparam int Y_R      = 32;
  localparam int WIDTH_L  = 31;
  localparam int WIDTH_R  = 22;
  localparam int HEIGHT_L = 21;
  localparam int HEIGHT_R = 12;
  localparam int COLOR_L  = 11;
  localparam int COLOR_R  = 0;

  // List operations issued by requesters
  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_UPDATE = 2'd1,
    OP_DELETE = 2'd2,
    OP_CLEAR  = 2'd3
  } op_e;

  // 12-bit RGB 4:4:4 colours
  localparam logic [11:0] COLOR_BLACK = 12'h000;
  localparam logic [11:0] COLOR_RED   = 12'hF00;
  localparam logic [11:0] COLOR_GREEN = 12'h0F0;
  localparam logic [11:0] COLOR_BLUE  = 12'h00F;
  localparam logic [11:0] COLOR_WHITE = 12'hFFF;

  // Assemble an object record from its fields
  function automatic logic [OBJ_WIDTH-1:0] make_obj(
    input logic [3:0]  kind,
    input logic [9:0]  x,
    input logic [9:0]  y,
    input logic [9:0]  w,
    input logic [9:0]  h,
    input logic [11:0] color
  );
    return {kind, x, y, w, h, color};
  endfunction

endpackage

`default_nettype wire

// File: rtl/obj_list_ctrl_rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter. Grants the first active request at or
//             after the pointer; the pointer moves past the grantee whenever
//             a grant is issued. N_REQ must be a power of two.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] next_ptr;
  logic [PW-1:0] cand;
  logic          found;

  // Scan requesters starting at the pointer; index wraps naturally (power of two)
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    cand     = ptr;
    found    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + PW'(k);
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        next_ptr    = cand + PW'(1);
      end
    end
  end

  // Advance the pointer only when a grant is actually issued
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= next_ptr;
    end
  end

endmodule

`default_nettype wire

// File: rtl/obj_list_ctrl.sv
// ============================================================================
//  Module   : obj_list_ctrl
//  Purpose  : Sequencer owning the renderer's object list. Requester ops are
//             serialised onto a shadow list; the shadow list is copied to the
//             display outputs only at frame start so a frame never sees a
//             half-edited list.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module obj_list_ctrl
  import obj_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int N_REQ   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_start,
  input  logic [N_REQ-1:0]               req,
  input  logic [2*N_REQ-1:0]             req_op,
  input  logic [IDX_W*N_REQ-1:0]         req_idx,
  input  logic [OBJ_WIDTH*N_REQ-1:0]     req_obj,
  output logic [N_REQ-1:0]               ack,
  output logic [N_REQ-1:0]               err,
  output logic [OBJ_WIDTH*MAX_LEN-1:0]   obj_arr_packed,
  output logic [LEN_W-1:0]               arr_len,
  output logic                           busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EXEC   = 3'd1;
  localparam logic [2:0] S_MOVE   = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  logic [2:0]           state;
  logic                 commit_pending;
  logic [OBJ_WIDTH-1:0] shadow [MAX_LEN];
  logic [OBJ_WIDTH-1:0] disp   [MAX_LEN];
  logic [LEN_W-1:0]     shadow_len;

  // Latched operation of the current grantee
  op_e                  cur_op;
  logic [IDX_W-1:0]     cur_idx;
  logic [OBJ_WIDTH-1:0] cur_obj;
  logic [N_REQ-1:0]     cur_sel;

  logic                 arb_en;
  logic [N_REQ-1:0]     grant;
  logic [1:0]           sel_op;
  logic [IDX_W-1:0]     sel_idx;
  logic [OBJ_WIDTH-1:0] sel_obj;
  logic                 full;
  logic                 idx_ok;
  logic                 exec_err;
  logic [IDX_W-1:0]     last_slot;

  // A pending or arriving commit takes precedence over any grant
  assign arb_en = (state == S_IDLE) && !commit_pending && !frame_start;
  assign busy   = (state != S_IDLE) || commit_pending;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .enable (arb_en),
    .req    (req),
    .grant  (grant)
  );

  // Route the granted requester's op, index and object
  always_comb begin
    sel_op  = '0;
    sel_idx = '0;
    sel_obj = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_op  = req_op[k*2 +: 2];
        sel_idx = req_idx[k*IDX_W +: IDX_W];
        sel_obj = req_obj[k*OBJ_WIDTH +: OBJ_WIDTH];
      end
    end
  end

  assign full   = (shadow_len == LEN_W'(MAX_LEN));
  assign idx_ok = (LEN_W'(cur_idx) < shadow_len);
  // Low bits of shadow_len-1; only used when the list is non-empty
  assign last_slot = shadow_len[IDX_W-1:0] - IDX_W'(1);

  // Decide whether the latched op is rejected
  always_comb begin
    exec_err = 1'b0;
    case (cur_op)
      OP_ADD:    exec_err = full;
      OP_UPDATE: exec_err = !idx_ok;
      OP_DELETE: exec_err = !idx_ok;
      OP_CLEAR:  exec_err = 1'b0;
    endcase
  end

  // Sequencer: arbitration, shadow list edits, ack/err generation
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      commit_pending <= 1'b0;
      shadow_len     <= '0;
      ack            <= '0;
      err            <= '0;
      cur_op         <= OP_ADD;
      cur_idx        <= '0;
      cur_obj        <= '0;
      cur_sel        <= '0;
      for (int i = 0; i < MAX_LEN; i++) shadow[i] <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      // Frame starts seen mid-op are remembered; one seen in COMMIT is absorbed
      if (frame_start && (state == S_EXEC || state == S_MOVE || state == S_RESP))
        commit_pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (commit_pending || frame_start) begin
            state <= S_COMMIT;
          end else if (|grant) begin
            cur_op  <= op_e'(sel_op);
            cur_idx <= sel_idx;
            cur_obj <= sel_obj;
            cur_sel <= grant;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cur_op == OP_DELETE && !exec_err) begin
            state <= S_MOVE;
          end else begin
            state <= S_RESP;
            ack   <= cur_sel;
            err   <= exec_err ? cur_sel : '0;
          end
          if (!exec_err) begin
            case (cur_op)
              OP_ADD: begin
                shadow[shadow_len[IDX_W-1:0]] <= cur_obj;
                shadow_len <= shadow_len + LEN_W'(1);
              end
              OP_UPDATE: shadow[cur_idx] <= cur_obj;
              OP_DELETE: ;
              OP_CLEAR: begin
                shadow_len <= '0;
                for (int i = 0; i < MAX_LEN; i++) shadow[i] <= '0;
              end
            endcase
          end
        end
        S_MOVE: begin
          // Swap-with-last; when idx is the last slot the zeroing write wins
          shadow[cur_idx]   <= shadow[last_slot];
          shadow[last_slot] <= '0;
          shadow_len        <= shadow_len - LEN_W'(1);
          state             <= S_RESP;
          ack               <= cur_sel;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        S_COMMIT: begin
          commit_pending <= 1'b0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Display list: copied from the shadow list only during COMMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      arr_len <= '0;
      for (int i = 0; i < MAX_LEN; i++) disp[i] <= '0;
    end else if (state == S_COMMIT) begin
      arr_len <= shadow_len;
      for (int i = 0; i < MAX_LEN; i++) disp[i] <= shadow[i];
    end
  end

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_pack
    assign obj_arr_packed[i*OBJ_WIDTH +: OBJ_WIDTH] = disp[i];
  end

endmodule

`default_nettype wire

// File: tb/tb_obj_list_ctrl.sv
// ============================================================================
//  Module   : tb_obj_list_ctrl
//  Purpose  : Directed self-checking bench for obj_list_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_obj_list_ctrl;

  localparam int OW = 56;
  localparam int ML = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           frame_start = 1'b0;
  logic [1:0]     req = '0;
  logic [3:0]     req_op = '0;
  logic [7:0]     req_idx = '0;
  logic [2*OW-1:0] req_obj = '0;
  logic [1:0]     ack;
  logic [1:0]     err;
  logic [OW*ML-1:0] obj_arr_packed;
  logic [5:0]     arr_len;
  logic           busy;

  int checks = 0;
  int failures = 0;

  obj_list_ctrl #(.MAX_LEN(16), .N_REQ(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .req            (req),
    .req_op         (req_op),
    .req_idx        (req_idx),
    .req_obj        (req_obj),
    .ack            (ack),
    .err            (err),
    .obj_arr_packed (obj_arr_packed),
    .arr_len        (arr_len),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] mk(input logic [3:0] k, input logic [9:0] x, input logic [9:0] y,
                                       input logic [9:0] w, input logic [9:0] h, input logic [11:0] c);
    return {k, x, y, w, h, c};
  endfunction

  function automatic logic [OW-1:0] slot(input int i);
    return obj_arr_packed[i*OW +: OW];
  endfunction

  // Issue one op from requester r; called at a negedge, returns at the negedge where ack is seen.
  // lat = negedges from request to ack (-1 on timeout).
  task automatic issue(input int r, input logic [1:0] op, input logic [3:0] idx, input logic [OW-1:0] obj,
                       output logic e, output int lat);
    req[r] = 1'b1;
    req_op[r*2 +: 2] = op;
    req_idx[r*4 +: 4] = idx;
    req_obj[r*OW +: OW] = obj;
    lat = -1;
    e = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack[r] === 1'b1) begin
        lat = n;
        e = err[r];
        break;
      end
    end
    req[r] = 1'b0;
  endtask

  // Frame pulse from IDLE; returns once the committed list is visible
  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", ack); end
    checks++; if (err !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", err); end
    checks++; if (arr_len !== 6'd0) begin failures++; $display("FAIL reset_len got=%0d exp=0", arr_len); end
    checks++; if (obj_arr_packed !== '0) begin failures++; $display("FAIL reset_arr got=nonzero exp=0"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_add_commit();
    logic e; int lat;
    logic [OW-1:0] g;
    g = mk(4'd0, 10'd100, 10'd100, 10'd100, 10'd100, 12'h0F0);
    issue(0, 2'd0, 4'd0, g, e, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL add_err got=%b exp=0", e); end
    @(negedge clk);
    checks++; if (arr_len !== 6'd0) begin failures++; $display("FAIL add_precommit_len got=%0d exp=0", arr_len); end
    frame_start = 1'b1;
    @(negedge clk);  // COMMIT cycle
    frame_start = 1'b0;
    checks++; if (arr_len !== 6'd0) begin failures++; $display("FAIL add_commitcyc_len got=%0d exp=0", arr_len); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL add_commitcyc_busy got=%b exp=1", busy); end
    @(negedge clk);
    checks++; if (arr_len !== 6'd1) begin failures++; $display("FAIL add_commit_len got=%0d exp=1", arr_len); end
    checks++; if (slot(0) !== g) begin failures++; $display("FAIL add_commit_slot0 got=%h exp=%h", slot(0), g); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_full();
    logic e; int lat; int nerr;
    issue(0, 2'd3, 4'd0, '0, e, lat);
    checks++; if (lat !== 2 || e !== 1'b0) begin failures++; $display("FAIL clear_resp got=lat%0d/err%b exp=lat2/err0", lat, e); end
    @(negedge clk);
    nerr = 0;
    for (int i = 0; i < 16; i++) begin
      issue(0, 2'd0, 4'd0, mk(4'd1, 10'(i * 10), 10'(i), 10'd20, 10'd20, 12'h00F), e, lat);
      if (e !== 1'b0 || lat !== 2) nerr++;
      @(negedge clk);
    end
    checks++; if (nerr !== 0) begin failures++; $display("FAIL full_adds got=%0d_bad exp=0_bad", nerr); end
    issue(0, 2'd0, 4'd0, mk(4'd2, 10'd1, 10'd1, 10'd1, 10'd1, 12'hF00), e, lat);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL full_17th_err got=%b exp=1", e); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL full_17th_lat got=%0d exp=2", lat); end
    @(negedge clk);
    pulse_frame();
    checks++; if (arr_len !== 6'd16) begin failures++; $display("FAIL full_len got=%0d exp=16", arr_len); end
    checks++; if (slot(0) !== mk(4'd1, 10'd0, 10'd0, 10'd20, 10'd20, 12'h00F)) begin failures++; $display("FAIL full_slot0 got=%h", slot(0)); end
    checks++; if (slot(15) !== mk(4'd1, 10'd150, 10'd15, 10'd20, 10'd20, 12'h00F)) begin failures++; $display("FAIL full_slot15 got=%h", slot(15)); end
    issue(0, 2'd3, 4'd0, '0, e, lat);
    @(negedge clk);
    pulse_frame();
    checks++; if (arr_len !== 6'd0) begin failures++; $display("FAIL clear_len got=%0d exp=0", arr_len); end
    checks++; if (obj_arr_packed !== '0) begin failures++; $display("FAIL clear_arr got=nonzero exp=0"); end
  endtask

  task automatic test_delete();
    logic e; int lat;
    logic [OW-1:0] a, b, c, d;
    a = mk(4'd1, 10'd10, 10'd11, 10'd12, 10'd13, 12'hF00);
    b = mk(4'd2, 10'd20, 10'd21, 10'd22, 10'd23, 12'h0F0);
    c = mk(4'd3, 10'd30, 10'd31, 10'd32, 10'd33, 12'h00F);
    d = mk(4'd4, 10'd40, 10'd41, 10'd42, 10'd43, 12'hFFF);
    issue(0, 2'd0, 4'd0, a, e, lat); @(negedge clk);
    issue(0, 2'd0, 4'd0, b, e, lat); @(negedge clk);
    issue(0, 2'd0, 4'd0, c, e, lat); @(negedge clk);
    pulse_frame();
    checks++; if (arr_len !== 6'd3) begin failures++; $display("FAIL del_pre_len got=%0d exp=3", arr_len); end
    issue(0, 2'd2, 4'd0, '0, e, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL del_latency got=%0d exp=3", lat); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL del_err got=%b exp=0", e); end
    @(negedge clk);
    pulse_frame();
    checks++; if (arr_len !== 6'd2) begin failures++; $display("FAIL del_len got=%0d exp=2", arr_len); end
    checks++; if (slot(0) !== c) begin failures++; $display("FAIL del_slot0 got=%h exp=%h", slot(0), c); end
    checks++; if (slot(1) !== b) begin failures++; $display("FAIL del_slot1 got=%h exp=%h", slot(1), b); end
    checks++; if (slot(2) !== '0) begin failures++; $display("FAIL del_slot2 got=%h exp=0", slot(2)); end
    issue(0, 2'd2, 4'd3, '0, e, lat);
    checks++; if (e !== 1'b1 || lat !== 2) begin failures++; $display("FAIL del_idx3 got=err%b/lat%0d exp=err1/lat2", e, lat); end
    @(negedge clk);
    issue(0, 2'd2, 4'd2, '0, e, lat);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL del_idx_eq_len got=%b exp=1", e); end
    @(negedge clk);
    issue(0, 2'd1, 4'd1, d, e, lat);
    checks++; if (e !== 1'b0 || lat !== 2) begin failures++; $display("FAIL upd_ok got=err%b/lat%0d exp=err0/lat2", e, lat); end
    @(negedge clk);
    issue(0, 2'd1, 4'd2, a, e, lat);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL upd_oob got=%b exp=1", e); end
    @(negedge clk);
    pulse_frame();
    checks++; if (slot(1) !== d) begin failures++; $display("FAIL upd_slot1 got=%h exp=%h", slot(1), d); end
    issue(0, 2'd2, 4'd1, '0, e, lat);
    checks++; if (e !== 1'b0 || lat !== 3) begin failures++; $display("FAIL del_last got=err%b/lat%0d exp=err0/lat3", e, lat); end
    @(negedge clk);
    pulse_frame();
    checks++; if (arr_len !== 6'd1) begin failures++; $display("FAIL del_last_len got=%0d exp=1", arr_len); end
    checks++; if (slot(0) !== c || slot(1) !== '0) begin failures++; $display("FAIL del_last_slots got=%h/%h exp=%h/0", slot(0), slot(1), c); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int multi;
    logic [OW-1:0] expv [6];
    for (int i = 0; i < 3; i++) begin
      expv[2*i]   = mk(4'd5, 10'(i), 10'd0, 10'd1, 10'd1, 12'h111);
      expv[2*i+1] = mk(4'd6, 10'(i), 10'd9, 10'd2, 10'd2, 12'h222);
    end
    do_reset();
    multi = 0;
    fork
      begin
        logic e0; int l0;
        for (int i = 0; i < 3; i++) begin
          issue(0, 2'd0, 4'd0, expv[2*i], e0, l0);
          @(negedge clk);
        end
      end
      begin
        logic e1; int l1;
        for (int i = 0; i < 3; i++) begin
          issue(1, 2'd0, 4'd0, expv[2*i+1], e1, l1);
          @(negedge clk);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          @(negedge clk);
          if (ack === 2'b11) multi++;
          else if (ack === 2'b01) order.push_back(0);
          else if (ack === 2'b10) order.push_back(1);
        end
      end
    join
    checks++; if (multi !== 0) begin failures++; $display("FAIL rr_multi_ack got=%0d exp=0", multi); end
    checks++; if (order.size() !== 6) begin failures++; $display("FAIL rr_ack_count got=%0d exp=6", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      checks++; if (order[k] !== (k % 2)) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, order[k], k % 2); end
    end
    pulse_frame();
    checks++; if (arr_len !== 6'd6) begin failures++; $display("FAIL rr_len got=%0d exp=6", arr_len); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (slot(k) !== expv[k]) begin failures++; $display("FAIL rr_slot%0d got=%h exp=%h", k, slot(k), expv[k]); end
    end
  endtask

  // List on entry: X0,Y0,X1,Y1,X2,Y2 (committed). DELETE idx1 -> X0,Y2,X1,Y1,X2
  task automatic test_frame_during_delete();
    logic [OW-1:0] z, y2, x2;
    int got;
    z  = mk(4'd7, 10'd7, 10'd7, 10'd7, 10'd7, 12'h777);
    y2 = mk(4'd6, 10'd2, 10'd9, 10'd2, 10'd2, 12'h222);
    x2 = mk(4'd5, 10'd2, 10'd0, 10'd1, 10'd1, 12'h111);
    req[0] = 1'b1; req_op[1:0] = 2'd2; req_idx[3:0] = 4'd1;   // IDLE: grant
    @(negedge clk);                                             // EXEC
    frame_start = 1'b1;
    req[1] = 1'b1; req_op[3:2] = 2'd0; req_obj[2*OW-1:OW] = z;
    @(negedge clk);                                             // MOVE
    frame_start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fdd_busy got=%b exp=1", busy); end
    @(negedge clk);                                             // RESP
    checks++; if (ack !== 2'b01 || err !== 2'b00) begin failures++; $display("FAIL fdd_ack got=%b/%b exp=01/00", ack, err); end
    req[0] = 1'b0;
    @(negedge clk);                                             // IDLE, commit pending
    checks++; if (arr_len !== 6'd6) begin failures++; $display("FAIL fdd_idle_len got=%0d exp=6", arr_len); end
    @(negedge clk);                                             // COMMIT
    @(negedge clk);                                             // IDLE, grant req1
    checks++; if (arr_len !== 6'd5) begin failures++; $display("FAIL fdd_len got=%0d exp=5", arr_len); end
    checks++; if (slot(1) !== y2 || slot(4) !== x2 || slot(5) !== '0) begin failures++; $display("FAIL fdd_slots got=%h/%h/%h", slot(1), slot(4), slot(5)); end
    got = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ack[1] === 1'b1) begin got = n; break; end
    end
    req[1] = 1'b0;
    checks++; if (got !== 2) begin failures++; $display("FAIL fdd_req1_latency got=%0d exp=2", got); end
    @(negedge clk);
    checks++; if (arr_len !== 6'd5) begin failures++; $display("FAIL fdd_no_extra_commit got=%0d exp=5", arr_len); end
  endtask

  task automatic test_reset_mid_move();
    logic e; int lat; int acks;
    logic [OW-1:0] w;
    w = mk(4'd9, 10'd300, 10'd200, 10'd50, 10'd40, 12'h0F0);
    pulse_frame();
    req[0] = 1'b1; req_op[1:0] = 2'd2; req_idx[3:0] = 4'd0;
    @(negedge clk);   // EXEC
    @(negedge clk);   // MOVE
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req[0] = 1'b0;
    checks++; if (ack !== 2'b00 || err !== 2'b00) begin failures++; $display("FAIL rmm_ack got=%b/%b exp=00/00", ack, err); end
    checks++; if (arr_len !== 6'd0 || obj_arr_packed !== '0) begin failures++; $display("FAIL rmm_outputs got=len%0d exp=len0,arr0", arr_len); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmm_busy got=%b exp=0", busy); end
    acks = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (ack !== 2'b00) acks++;
    end
    checks++; if (acks !== 0) begin failures++; $display("FAIL rmm_stray_ack got=%0d exp=0", acks); end
    issue(0, 2'd0, 4'd0, w, e, lat);
    checks++; if (e !== 1'b0 || lat !== 2) begin failures++; $display("FAIL rmm_add got=err%b/lat%0d exp=err0/lat2", e, lat); end
    @(negedge clk);
    pulse_frame();
    checks++; if (arr_len !== 6'd1 || slot(0) !== w) begin failures++; $display("FAIL rmm_commit got=len%0d/%h exp=1/%h", arr_len, slot(0), w); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add_commit();
    test_full();
    test_delete();
    test_round_robin();
    test_frame_during_delete();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
